// File: rtl/gcd_engine.sv
// Iterative GCD engine: subtractive Euclid or binary Stein, selected per job.
// One-cycle done pulse; result and iteration count held until the next completion.
module gcd_engine #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mode,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] iter_count
);

    localparam int unsigned KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;
    logic [WIDTH-1:0] a_shifted;
    logic [CNT_W-1:0] cnt_inc;

    // Only the difference with the larger operand as minuend is ever selected.
    assign diff_ab   = a_q - b_q;
    assign diff_ba   = b_q - a_q;
    assign a_shifted = a_q << k_q;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        iter_d  = iter_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (a_in == '0 || b_in == '0) begin
                        gcd_d   = a_in | b_in;
                        iter_d  = '0;
                        state_d = StDone;
                    end else begin
                        a_d     = a_in;
                        b_d     = b_in;
                        k_d     = '0;
                        cnt_d   = '0;
                        mode_d  = mode;
                        state_d = StCalc;
                    end
                end
            end

            StCalc: begin
                if (a_q == b_q) begin
                    gcd_d   = mode_q ? a_shifted : a_q;
                    iter_d  = cnt_q;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_inc;
                    if (!mode_q) begin
                        if (a_q > b_q) a_d = diff_ab;
                        else           b_d = diff_ba;
                    end else if (!a_q[0] && !b_q[0]) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + KW'(1);
                    end else if (!a_q[0]) begin
                        a_d = a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_d = b_q >> 1;
                    end else if (a_q > b_q) begin
                        a_d = diff_ab;
                    end else begin
                        b_d = diff_ba;
                    end
                end
            end

            StDone: state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            iter_q  <= iter_d;
        end
    end

    assign ready      = (state_q == StIdle);
    assign done       = (state_q == StDone);
    assign gcd_out    = gcd_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: scoreboard of expected results checked on each done pulse,
// plus latency, pulse-width, abort and 8-bit boundary checks.
module tb_gcd_engine;

    typedef struct {
        logic [15:0] g;
        logic [15:0] i;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        mode = 1'b0;
    logic        ready, done;
    logic [15:0] gcd_out, iter_count;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       ready8a, done8a, ready8b, done8b;
    logic [7:0] g8a, i8a, g8b;
    logic [3:0] i8b;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    gcd_engine #(.WIDTH(16), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .a_in(a_in), .b_in(b_in),
        .mode(mode), .ready(ready), .done(done), .gcd_out(gcd_out), .iter_count(iter_count)
    );

    gcd_engine #(.WIDTH(8), .CNT_W(8)) dut8a (
        .clock(clock), .reset_n(reset_n), .start(start8), .a_in(a8), .b_in(b8),
        .mode(1'b0), .ready(ready8a), .done(done8a), .gcd_out(g8a), .iter_count(i8a)
    );

    gcd_engine #(.WIDTH(8), .CNT_W(4)) dut8b (
        .clock(clock), .reset_n(reset_n), .start(start8), .a_in(a8), .b_in(b8),
        .mode(1'b0), .ready(ready8b), .done(done8b), .gcd_out(g8b), .iter_count(i8b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && done) begin
            chk("sb_pending", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_gcd", gcd_out, e.g);
                chk("sb_iter", iter_count, e.i);
            end
        end
    end

    task automatic run_job(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic m, input logic [15:0] eg, input logic [15:0] ei,
                           input int exp_lat);
        int lat;
        @(negedge clock);
        chk({tag, "_ready"}, ready, 1);
        a_in  = a;
        b_in  = b;
        mode  = m;
        start = 1'b1;
        sb.push_back('{eg, ei});
        @(negedge clock);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 1000) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        @(negedge clock);
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_ready_back"}, ready, 1);
    endtask

    initial begin
        int seen;
        int last;
        int lat;

        #12;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_gcd", gcd_out, 0);
        chk("rst_iter", iter_count, 0);
        @(negedge clock);
        reset_n = 1'b1;

        run_job("euc_169_39", 16'd169, 16'd39, 1'b0, 16'd13, 16'd6, 7);
        run_job("bin_169_39", 16'd169, 16'd39, 1'b1, 16'd13, 16'd6, 7);
        run_job("bin_48_18", 16'd48, 16'd18, 1'b1, 16'd6, 16'd6, 7);
        run_job("euc_48_18", 16'd48, 16'd18, 1'b0, 16'd6, 16'd4, 5);
        run_job("zero_0_25", 16'd0, 16'd25, 1'b0, 16'd25, 16'd0, 0);
        run_job("zero_0_0", 16'd0, 16'd0, 1'b1, 16'd0, 16'd0, 0);
        run_job("eq_7_7", 16'd7, 16'd7, 1'b0, 16'd7, 16'd0, 1);

        // Start pulsed mid-CALC with other operands must be ignored.
        @(negedge clock);
        a_in = 16'd169; b_in = 16'd39; mode = 1'b0; start = 1'b1;
        sb.push_back('{16'd13, 16'd6});
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        a_in = 16'd48; b_in = 16'd18; mode = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 1000) begin
            @(negedge clock);
            lat++;
        end
        chk("ign_lat", lat, 5);
        repeat (12) @(negedge clock);
        chk("ign_hold_gcd", gcd_out, 13);
        chk("ign_hold_iter", iter_count, 6);

        // Start held high: accepted only when ready, one job per 9 edges.
        repeat (3) sb.push_back('{16'd13, 16'd6});
        a_in = 16'd169; b_in = 16'd39; mode = 1'b0; start = 1'b1;
        seen = 0;
        last = 0;
        for (int c = 0; c < 300 && seen < 3; c++) begin
            @(negedge clock);
            if (done) begin
                if (seen > 0) chk("held_gap", c - last, 9);
                last = c;
                seen++;
                if (seen == 3) start = 1'b0;
            end
        end
        chk("held_jobs", seen, 3);
        repeat (12) @(negedge clock);

        // Asynchronous reset mid-CALC aborts with no done pulse.
        a_in = 16'd169; b_in = 16'd39; mode = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_gcd", gcd_out, 0);
        chk("abort_iter", iter_count, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        run_job("after_abort", 16'd169, 16'd39, 1'b0, 16'd13, 16'd6, 7);

        // 8-bit boundary: 254 subtractions, one instance saturating a 4-bit counter.
        @(negedge clock);
        chk("w8_ready", {ready8a, ready8b}, 2'b11);
        a8 = 8'd255; b8 = 8'd1; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        lat = 0;
        while (!done8a && lat < 2000) begin
            @(negedge clock);
            lat++;
        end
        chk("w8_lat", lat, 255);
        chk("w8_done_both", {done8a, done8b}, 2'b11);
        chk("w8_gcd", g8a, 1);
        chk("w8_iter", i8a, 254);
        chk("w8_sat_gcd", g8b, 1);
        chk("w8_sat_iter", i8b, 15);
        @(negedge clock);
        chk("w8_pulse", {done8a, done8b}, 2'b00);

        repeat (3) @(negedge clock);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
